adc_spi_reader: RTL and testbench
=================================

ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 Parameter ADC_BITWIDTH, default 8: width of the converted sample and of ADC_value_o.
REQ-002 Parameter CLK_DIV, default 4: SCLK half-period in clk_i cycles; legal range 2..255.
REQ-003 Parameter SAMPLE_PERIOD, default 1000: clk_i cycles between conversion starts; legal when ≥ (2*16+1)*CLK_DIV+2.
REQ-004 Port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-005 Port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 Port en_i, input, 1: conversions permitted while high.
REQ-007 Port adc_miso_i, input, 1: serial data from the external 8-bit SPI ADC (16-clock frame).
REQ-008 Port adc_cs_n_o, output, 1: ADC chip select, active low.
REQ-009 Port adc_sclk_o, output, 1: ADC serial clock, idle low.
REQ-010 Port ADC_value_o, output, ADC_BITWIDTH: last completed sample, unsigned; feeds FanCTRL ADC_value_i.
REQ-011 Port dataValid_STRB_o, output, 1: one-cycle pulse when ADC_value_o updates; feeds FanCTRL dataValid_STRB_i.
REQ-012 Port overrun_o, output, 1: one-cycle pulse when a sample tick arrives while a frame is in progress.

Function
REQ-013 Sample timer: free-running counter 0..SAMPLE_PERIOD-1, wraps to 0; tick when value equals SAMPLE_PERIOD-1.
REQ-014 FSM states: IDLE, CS_SETUP, SHIFT, DONE.
REQ-015 IDLE -> CS_SETUP on tick with en_i high; otherwise remains in IDLE; tick with en_i low ignored, no overrun.
REQ-016 CS_SETUP: adc_cs_n_o low, adc_sclk_o low, hold CLK_DIV cycles, then go to SHIFT.
REQ-017 SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high; adc_miso_i sampled on the clk_i edge where adc_sclk_o goes high.
REQ-018 Frame bits MSB first; bits 3..10 (0-based, 0 = first sampled) form the sample; other bits are discarded.
REQ-019 After the 16th high phase: adc_sclk_o low, go to DONE.
REQ-020 DONE (one cycle): adc_cs_n_o high, ADC_value_o updated, dataValid_STRB_o high for exactly this cycle, go to IDLE.
REQ-021 Latency from tick to strobe = 1 + CLK_DIV + 32*CLK_DIV + 1 cycles (134 at CLK_DIV=4).
REQ-022 Tick in any state other than IDLE: tick dropped, overrun_o pulses that cycle, frame unaffected.
REQ-023 en_i deasserted mid-frame: current frame completes normally; no new frame starts.
REQ-024 ADC_value_o holds between strobes; never changes without dataValid_STRB_o.

Reset
REQ-025 rst_i high: FSM IDLE, timer 0, adc_cs_n_o 1, adc_sclk_o 0, ADC_value_o 0, dataValid_STRB_o 0, overrun_o 0, shift register 0.
REQ-026 Reset mid-frame aborts the frame immediately (CS high asynchronously); no strobe is issued for it.

Configuration
REQ-027 Macro ADC_AVG_EN defined: 4-entry history of raw samples (reset to 0); in DONE, ADC_value_o = (sum of newest 4) >> 2, truncated; strobe timing unchanged.
REQ-028 ADC_AVG_EN undefined: ADC_value_o = raw sample; no history registers.

Structure
REQ-029 Shared package fanctrl_pkg holds the FSM state enum, ADC frame length (16), and data bit-position constants.
REQ-030 One sub-module, adc_avg4, implements the averaging history; it is instantiated only under ADC_AVG_EN.

Verification
REQ-031 SPI ADC model returns 0xA5 in bits 3..10, SAMPLE_PERIOD=1000, CLK_DIV=4 -> strobe 134 cycles after tick, ADC_value_o=0xA5, exactly 16 SCLK rising edges while CS low.
REQ-032 SAMPLE_PERIOD=100 (< frame length) -> overrun_o pulses on the tick during the frame; frames still complete with correct data.
REQ-033 en_i dropped 20 cycles into a frame -> that frame strobes normally; no further CS activity while en_i is low.
REQ-034 rst_i asserted 50 cycles into a frame -> CS high immediately, no strobe, ADC_value_o=0; next frame after release reads correctly.
REQ-035 ADC_AVG_EN, model returns 0x10, 0x20, 0x30, 0x40 -> ADC_value_o = 0x04, 0x0C, 0x18, 0x28.
REQ-036 Model returns 0xFF then 0x00 -> ADC_value_o 0xFF then 0x00; discarded frame bits driven to 1 do not corrupt the result.

Source files
------------

// File: rtl/fanctrl_pkg.sv
// Shared definitions for the fan-controller ADC front end: reader FSM states and
// the layout of the 16-clock frame returned by the external 8-bit SPI ADC.
package fanctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CS_SETUP = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_DONE     = 2'd3
   } adcState_e;

   localparam int ADC_FRAME_LEN      = 16;
   localparam int ADC_DATA_FIRST_BIT = 3;
   localparam int ADC_DATA_LAST_BIT  = 10;
   localparam int ADC_RAW_W          = ADC_DATA_LAST_BIT - ADC_DATA_FIRST_BIT + 1;

   // Bits sampled before the first data bit fall off the top of the shifter,
   // so it only needs to span from the data MSB to the last frame bit.
   localparam int ADC_SHIFT_W        = ADC_FRAME_LEN - ADC_DATA_FIRST_BIT;

endpackage

// File: rtl/adc_avg4.sv
// Running average over the four newest raw ADC samples; only instantiated by
// adc_spi_reader when ADC_AVG_EN is defined.
module adc_avg4
   import fanctrl_pkg::*;
#(
   parameter int W = ADC_RAW_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] sample_i,
   output logic [W-1:0] avg_o
);

   logic [W-1:0] hist_q [4];
   logic [W+1:0] sum;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      end else if (load_i) begin
         hist_q[0] <= sample_i;
         for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
      end
   end

   assign sum   = (W+2)'(hist_q[0]) + (W+2)'(hist_q[1]) + (W+2)'(hist_q[2]) + (W+2)'(hist_q[3]);
   assign avg_o = W'(sum >> 2);

endmodule

// File: rtl/adc_spi_reader.sv
// Periodic SPI reader for the fan-controller ADC; define ADC_AVG_EN to report a
// four-sample running average instead of the raw conversion.
module adc_spi_reader
   import fanctrl_pkg::*;
#(
   parameter int ADC_BITWIDTH  = 8,
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    adc_miso_i,
   output logic                    adc_cs_n_o,
   output logic                    adc_sclk_o,
   output logic [ADC_BITWIDTH-1:0] ADC_value_o,
   output logic                    dataValid_STRB_o,
   output logic                    overrun_o
);

   localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [3:0]       BIT_LAST = 4'(ADC_FRAME_LEN - 1);

   adcState_e              state_q, state_d;
   logic [TMR_W-1:0]       timer_q;
   logic [7:0]             div_q, div_d;
   logic [3:0]             bitCnt_q, bitCnt_d;
   logic                   sclk_q, sclk_d;
   logic                   csN_q, csN_d;
   logic [ADC_SHIFT_W-1:0] shift_q, shift_d;
   logic                   tick;
   logic                   loadSample;
   logic [ADC_RAW_W-1:0]   rawSample;

   assign tick      = (timer_q == TMR_LAST);
   assign rawSample = shift_q[ADC_SHIFT_W-1 -: ADC_RAW_W];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     timer_q <= '0;
      else if (tick) timer_q <= '0;
      else           timer_q <= timer_q + 1'b1;
   end

   // SCLK toggles every CLK_DIV cycles; MISO is captured on the toggle that raises SCLK.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bitCnt_d   = bitCnt_q;
      sclk_d     = sclk_q;
      csN_d      = csN_q;
      shift_d    = shift_q;
      loadSample = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick && en_i) begin
               state_d = ST_CS_SETUP;
               csN_d   = 1'b0;
               div_d   = '0;
            end
         end
         ST_CS_SETUP: begin
            if (div_q == DIV_LAST) begin
               state_d  = ST_SHIFT;
               div_d    = '0;
               bitCnt_d = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  shift_d = {shift_q[ADC_SHIFT_W-2:0], adc_miso_i};
               end else if (bitCnt_q == BIT_LAST) begin
                  state_d    = ST_DONE;
                  csN_d      = 1'b1;
                  loadSample = 1'b1;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         bitCnt_q <= '0;
         sclk_q   <= 1'b0;
         csN_q    <= 1'b1;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bitCnt_q <= bitCnt_d;
         sclk_q   <= sclk_d;
         csN_q    <= csN_d;
         shift_q  <= shift_d;
      end
   end

`ifdef ADC_AVG_EN
   logic [ADC_RAW_W-1:0] avgValue;

   adc_avg4 #(.W(ADC_RAW_W)) u_avg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (loadSample),
      .sample_i (rawSample),
      .avg_o    (avgValue)
   );

   assign ADC_value_o = ADC_BITWIDTH'(avgValue);
`else
   logic [ADC_BITWIDTH-1:0] value_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)           value_q <= '0;
      else if (loadSample) value_q <= ADC_BITWIDTH'(rawSample);
   end

   assign ADC_value_o = value_q;
`endif

   assign adc_cs_n_o       = csN_q;
   assign adc_sclk_o       = sclk_q;
   assign dataValid_STRB_o = (state_q == ST_DONE);
   assign overrun_o        = tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: SPI ADC models feed known 16-bit frames to a
// SAMPLE_PERIOD=1000 instance and to a SAMPLE_PERIOD=100 instance that overruns.
module tb_adc_spi_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       miso = 1'b0;
   logic       csN, sclk, strobe, overrun;
   logic [7:0] value;

   logic       rst2 = 1'b1;
   logic       en2  = 1'b1;
   logic       miso2 = 1'b0;
   logic       csN2, sclk2, strobe2, overrun2;
   logic [7:0] value2;

   always #5 clk = ~clk;

   adc_spi_reader #(.ADC_BITWIDTH(8), .CLK_DIV(4), .SAMPLE_PERIOD(1000)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .en_i             (en),
      .adc_miso_i       (miso),
      .adc_cs_n_o       (csN),
      .adc_sclk_o       (sclk),
      .ADC_value_o      (value),
      .dataValid_STRB_o (strobe),
      .overrun_o        (overrun)
   );

   adc_spi_reader #(.ADC_BITWIDTH(8), .CLK_DIV(4), .SAMPLE_PERIOD(100)) dut2 (
      .clk_i            (clk),
      .rst_i            (rst2),
      .en_i             (en2),
      .adc_miso_i       (miso2),
      .adc_cs_n_o       (csN2),
      .adc_sclk_o       (sclk2),
      .ADC_value_o      (value2),
      .dataValid_STRB_o (strobe2),
      .overrun_o        (overrun2)
   );

   // ADC models: bit 0 of the frame is presented when CS falls, each following
   // bit right after the SCLK rising edge that captured the previous one.
   logic [15:0] frame1 = 16'h0000;
   logic [15:0] frame2 = 16'h0D20;
   int idx1 = 0, rise1 = 0, idx2 = 0;

   always @(negedge csN) begin
      idx1 = 0;
      rise1 = 0;
      miso = frame1[15];
   end

   always @(posedge sclk) begin
      if (!csN) begin
         rise1++;
         idx1++;
         if (idx1 < 16) miso = frame1[15 - idx1];
         else           miso = 1'b0;
      end
   end

   always @(negedge csN2) begin
      idx2 = 0;
      miso2 = frame2[15];
   end

   always @(posedge sclk2) begin
      if (!csN2) begin
         idx2++;
         if (idx2 < 16) miso2 = frame2[15 - idx2];
         else           miso2 = 1'b0;
      end
   end

   // Cycle index since reset release; equals the DUT sample-timer value modulo the period.
   int cyc = 0, cyc2 = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end
   always @(posedge clk or posedge rst2) begin
      if (rst2) cyc2 <= 0;
      else      cyc2 <= cyc2 + 1;
   end

   int csFallCyc = 0, csLowCnt = 0, strobeCnt = 0, overrunCnt = 0, holdErr = 0;
   logic prevCs = 1'b1;
   logic [7:0] prevValue = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         prevCs = 1'b1;
         prevValue = value;
      end else begin
         if (prevCs && !csN) csFallCyc = cyc;
         if (!csN) csLowCnt++;
         if (strobe) strobeCnt++;
         if (overrun) overrunCnt++;
         if (value !== prevValue && !strobe) holdErr++;
         prevCs = csN;
         prevValue = value;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] f);
      frame1 = f;
   endtask

   // Expected ADC_value_o of the main instance for each newly captured raw sample.
   logic [7:0] hist [4];

   task automatic clearHist();
      for (int i = 0; i < 4; i++) hist[i] = 8'h00;
   endtask

   task automatic pushExp(input logic [7:0] raw, output logic [7:0] expv);
`ifdef ADC_AVG_EN
      int s;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = raw;
      s = int'(hist[0]) + int'(hist[1]) + int'(hist[2]) + int'(hist[3]);
      expv = 8'(s / 4);
`else
      expv = raw;
`endif
   endtask

   task automatic waitStrobe(input int budget, output bit ok, output int atCyc);
      ok = 1'b0;
      atCyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (strobe) begin
            ok = 1'b1;
            atCyc = cyc;
            break;
         end
      end
   endtask

   task automatic waitCsFall(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!csN) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  expRaw;
   } vec_t;

   vec_t vecs [5];

   initial begin
      bit ok;
      int sc, sb, lowBefore;
      logic [7:0] expv;
      int ovCnt2, ov1, ov2, stCnt2, st1, st2, v1, v2;

      vecs[0] = '{16'h14A0, 8'hA5};
      vecs[1] = '{16'h1FE0, 8'hFF};
      vecs[2] = '{16'hE01F, 8'h00};
      vecs[3] = '{16'hA78A, 8'h3C};
      vecs[4] = '{16'h5035, 8'h81};

      clearHist();
      repeat (3) @(negedge clk);
      checkOutput("reset cs_n", int'(csN), 1);
      checkOutput("reset sclk", int'(sclk), 0);
      checkOutput("reset value", int'(value), 0);
      checkOutput("reset strobe", int'(strobe), 0);
      checkOutput("reset overrun", int'(overrun), 0);

      en  = 1'b1;
      rst = 1'b0;

`ifdef ADC_AVG_EN
      begin
         logic [15:0] avgFrames [4];
         logic [7:0]  avgRaw [4];
         logic [7:0]  avgExp [4];
         avgFrames = '{16'h0200, 16'h0400, 16'h0600, 16'h0800};
         avgRaw    = '{8'h10, 8'h20, 8'h30, 8'h40};
         avgExp    = '{8'h04, 8'h0C, 8'h18, 8'h28};
         for (int i = 0; i < 4; i++) begin
            applyStimulus(avgFrames[i]);
            pushExp(avgRaw[i], expv);
            waitStrobe(1200, ok, sc);
            checkOutput("avg strobe seen", int'(ok), 1);
            checkOutput("avg value", int'(value), int'(avgExp[i]));
         end
      end
`endif

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].frame);
         pushExp(vecs[i].expRaw, expv);
         waitStrobe(1200, ok, sc);
         checkOutput("vector strobe seen", int'(ok), 1);
         checkOutput("vector value", int'(value), int'(expv));
         checkOutput("cs fall follows tick", csFallCyc % 1000, 0);
         checkOutput("tick-to-strobe latency", sc - csFallCyc + 2, 134);
         checkOutput("sclk rises per frame", rise1, 16);
      end

      // en_i dropped 20 cycles into a frame
      applyStimulus(16'h0B40);
      pushExp(8'h5A, expv);
      waitCsFall(1100, ok);
      checkOutput("en-drop frame start", int'(ok), 1);
      repeat (20) @(negedge clk);
      en = 1'b0;
      waitStrobe(200, ok, sc);
      checkOutput("en-drop strobe seen", int'(ok), 1);
      checkOutput("en-drop value", int'(value), int'(expv));
      lowBefore = csLowCnt;
      repeat (2500) @(negedge clk);
      checkOutput("cs idle while disabled", csLowCnt - lowBefore, 0);
      en = 1'b1;

      // reset asserted 50 cycles into a frame
      applyStimulus(16'hFFFF);
      waitCsFall(1100, ok);
      checkOutput("reset-test frame start", int'(ok), 1);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("async reset cs_n", int'(csN), 1);
      checkOutput("async reset sclk", int'(sclk), 0);
      checkOutput("async reset value", int'(value), 0);
      checkOutput("async reset strobe", int'(strobe), 0);
      clearHist();
      applyStimulus(16'hF2DF);
      repeat (3) @(negedge clk);
      sb = strobeCnt;
      rst = 1'b0;
      pushExp(8'h96, expv);
      waitStrobe(1200, ok, sc);
      @(negedge clk);
      checkOutput("post-reset strobe seen", int'(ok), 1);
      checkOutput("post-reset strobe cycle", sc, 1132);
      checkOutput("post-reset value", int'(value), int'(expv));
      checkOutput("single strobe after reset", strobeCnt - sb, 1);

      // SAMPLE_PERIOD=100 instance: ticks at 99, 199, 299, 399; frames 99..232 and 299..432
      ovCnt2 = 0; ov1 = -1; ov2 = -1; stCnt2 = 0; st1 = -1; st2 = -1; v1 = -1; v2 = -1;
      @(negedge clk);
      rst2 = 1'b0;
      repeat (460) begin
         @(negedge clk);
         if (overrun2) begin
            ovCnt2++;
            if (ovCnt2 == 1) ov1 = cyc2;
            if (ovCnt2 == 2) ov2 = cyc2;
         end
         if (strobe2) begin
            stCnt2++;
            if (stCnt2 == 1) begin st1 = cyc2; v1 = int'(value2); end
            if (stCnt2 == 2) begin st2 = cyc2; v2 = int'(value2); end
         end
      end
      checkOutput("overrun count", ovCnt2, 2);
      checkOutput("first overrun cycle", ov1, 199);
      checkOutput("second overrun cycle", ov2, 399);
      checkOutput("overrun strobe count", stCnt2, 2);
      checkOutput("overrun first strobe cycle", st1, 232);
      checkOutput("overrun second strobe cycle", st2, 432);
`ifdef ADC_AVG_EN
      checkOutput("overrun first value", v1, 8'h1A);
      checkOutput("overrun second value", v2, 8'h34);
`else
      checkOutput("overrun first value", v1, 8'h69);
      checkOutput("overrun second value", v2, 8'h69);
`endif

      checkOutput("main instance overrun pulses", overrunCnt, 0);
      checkOutput("value changed without strobe", holdErr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
